// File: rtl/sram_like_arbiter_pkg.sv
// Shared types for the SRAM-like port arbiter: the CPU data word and the
// owner tag, request/response bundles and default sizing for the arbiter.
package cpu_core_params;
  typedef logic [31:0] cpu_data_t;
endpackage

package arbiter_params;
  import cpu_core_params::*;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_t;

  typedef struct packed {
    logic       request;
    logic       write;
    logic [1:0] size;
    cpu_data_t  address;
    cpu_data_t  write_data;
    logic [3:0] write_strobe;
  } sram_request_t;

  typedef struct packed {
    cpu_data_t read_data;
    logic      address_ready;
    logic      data_ready;
  } sram_response_t;

  localparam int DEFAULT_MAX_OUTSTANDING = 4;
  localparam int DEFAULT_STARVE_LIMIT    = 8;
endpackage

// File: rtl/sram_like_arbiter_if.sv
// One SRAM-like port: the requester drives the master side, the responder
// (memory, bridge or arbiter) drives the slave side.
interface sram_like_arbiter_if;
  import cpu_core_params::*;

  logic       request;
  logic       write;
  logic [1:0] size;
  cpu_data_t  address;
  cpu_data_t  write_data;
  logic [3:0] write_strobe;
  cpu_data_t  read_data;
  logic       address_ready;
  logic       data_ready;

  modport master (
    output request, write, size, address, write_data, write_strobe,
    input  read_data, address_ready, data_ready
  );

  modport slave (
    input  request, write, size, address, write_data, write_strobe,
    output read_data, address_ready, data_ready
  );
endinterface

// File: rtl/sram_like_arbiter_owner_fifo.sv
// In-order FIFO of owner tags, one entry per accepted transaction that is
// still waiting for its data phase. Pointers wrap naturally because the
// depth is a power of two.
module owner_fifo
  import arbiter_params::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  owner_t        push_owner,
  input  logic          pop,
  output owner_t        head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  owner_t        entries [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = entries[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge clock) begin
    if (do_push) entries[wr_ptr] <= push_owner;
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop keeps count.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and the data
// requester. Data wins by default, a stalled address phase stays locked to
// its owner, and a starvation counter forces a fetch grant after a run of
// data grants. Responses come back in order and are routed by an owner FIFO.
module sram_like_arbiter
  import arbiter_params::*;
#(
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter int STARVE_LIMIT    = DEFAULT_STARVE_LIMIT
) (
  input  logic                       clock,
  input  logic                       reset,
  sram_like_arbiter_if.slave         inst_ram,
  sram_like_arbiter_if.slave         data_ram,
  sram_like_arbiter_if.master        ram,
  output logic                       protocol_error
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  sram_request_t  inst_req;
  sram_request_t  data_req;
  sram_request_t  granted_req;
  sram_response_t inst_rsp;
  sram_response_t data_rsp;

  logic          grant_valid;
  owner_t        grant_owner;
  logic          lock_valid;
  owner_t        lock_owner;
  logic          locked_still_requesting;
  logic [SW-1:0] starve_count;
  logic          accept;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  owner_t        fifo_head;
  logic [CW-1:0] fifo_count;

  assign inst_req = '{request: inst_ram.request, write: inst_ram.write,
                      size: inst_ram.size, address: inst_ram.address,
                      write_data: inst_ram.write_data,
                      write_strobe: inst_ram.write_strobe};
  assign data_req = '{request: data_ram.request, write: data_ram.write,
                      size: data_ram.size, address: data_ram.address,
                      write_data: data_ram.write_data,
                      write_strobe: data_ram.write_strobe};

  assign locked_still_requesting = (lock_owner == OWNER_DATA) ? data_ram.request
                                                              : inst_ram.request;

  // Pick at most one requester per cycle; nothing is granted while the FIFO is full.
  always_comb begin
    grant_valid = 1'b0;
    grant_owner = OWNER_INST;
    if (!fifo_full) begin
      if (lock_valid && locked_still_requesting) begin
        grant_valid = 1'b1;
        grant_owner = lock_owner;
      end else if (starve_count == STARVE_MAX && inst_ram.request) begin
        grant_valid = 1'b1;
        grant_owner = OWNER_INST;
      end else if (data_ram.request) begin
        grant_valid = 1'b1;
        grant_owner = OWNER_DATA;
      end else if (inst_ram.request) begin
        grant_valid = 1'b1;
        grant_owner = OWNER_INST;
      end
    end
  end

  // Forward the winner's fields; with no winner the fetch fields pass through.
  always_comb begin
    granted_req = (grant_owner == OWNER_DATA) ? data_req : inst_req;
  end

  assign ram.request      = grant_valid;
  assign ram.write        = granted_req.write;
  assign ram.size         = granted_req.size;
  assign ram.address      = granted_req.address;
  assign ram.write_data   = granted_req.write_data;
  assign ram.write_strobe = granted_req.write_strobe;

  assign accept = grant_valid && ram.address_ready;
  assign pop    = ram.data_ready && !fifo_empty;

  assign inst_rsp = '{read_data: ram.read_data,
                      address_ready: accept && (grant_owner == OWNER_INST),
                      data_ready: pop && (fifo_head == OWNER_INST)};
  assign data_rsp = '{read_data: ram.read_data,
                      address_ready: accept && (grant_owner == OWNER_DATA),
                      data_ready: pop && (fifo_head == OWNER_DATA)};

  assign inst_ram.read_data     = inst_rsp.read_data;
  assign inst_ram.address_ready = inst_rsp.address_ready;
  assign inst_ram.data_ready    = inst_rsp.data_ready;
  assign data_ram.read_data     = data_rsp.read_data;
  assign data_ram.address_ready = data_rsp.address_ready;
  assign data_ram.data_ready    = data_rsp.data_ready;

  owner_fifo #(.DEPTH(MAX_OUTSTANDING)) u_owner_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (accept),
    .push_owner (grant_owner),
    .pop        (pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // Hold a stalled address phase on its owner until accepted or withdrawn.
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_valid <= 1'b0;
      lock_owner <= OWNER_INST;
    end else begin
      lock_valid <= grant_valid && !ram.address_ready;
      if (grant_valid) lock_owner <= grant_owner;
    end
  end

  // Count data accepts that overtook a waiting fetch, saturating at the limit.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_count <= '0;
    end else if (!inst_ram.request) begin
      starve_count <= '0;
    end else if (accept && grant_owner == OWNER_INST) begin
      starve_count <= '0;
    end else if (accept && grant_owner == OWNER_DATA && starve_count != STARVE_MAX) begin
      starve_count <= starve_count + 1'b1;
    end
  end

  // A response with nothing outstanding is flagged until the next reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      protocol_error <= 1'b0;
    end else if (ram.data_ready && fifo_empty) begin
      protocol_error <= 1'b1;
    end
  end

  // Owner FIFO never holds more than its depth.
  assert property (@(posedge clock) disable iff (reset) fifo_count <= CW'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios plus
// randomized traffic compared each cycle against a queue-based model.
module tb_sram_like_arbiter;
  localparam int MAX_OUT = 4;
  localparam int STARVE  = 8;

  logic clock = 1'b0;
  logic reset;
  logic protocol_error;

  sram_like_arbiter_if inst_if ();
  sram_like_arbiter_if data_if ();
  sram_like_arbiter_if ram_if ();

  always #5 clock = ~clock;

  sram_like_arbiter #(.MAX_OUTSTANDING(MAX_OUT), .STARVE_LIMIT(STARVE)) dut (
    .clock          (clock),
    .reset          (reset),
    .inst_ram       (inst_if),
    .data_ram       (data_if),
    .ram            (ram_if),
    .protocol_error (protocol_error)
  );

  // Reference model state: outstanding owners in order (0 = inst, 1 = data).
  int owner_q[$];
  bit lock_valid;
  int lock_owner;
  int starve;
  bit perr;
  int tests = 0;
  int failures = 0;
  int inst_accepts;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic int modelGrant();
    bit ireq = inst_if.request;
    bit dreq = data_if.request;
    if (owner_q.size() >= MAX_OUT) return -1;
    if (lock_valid && ((lock_owner == 1) ? dreq : ireq)) return lock_owner;
    if (starve == STARVE && ireq) return 0;
    if (dreq) return 1;
    if (ireq) return 0;
    return -1;
  endfunction

  task automatic clearInputs();
    inst_if.request = 0; inst_if.write = 0; inst_if.size = 0;
    inst_if.address = 0; inst_if.write_data = 0; inst_if.write_strobe = 0;
    data_if.request = 0; data_if.write = 0; data_if.size = 0;
    data_if.address = 0; data_if.write_data = 0; data_if.write_strobe = 0;
    ram_if.address_ready = 0; ram_if.data_ready = 0; ram_if.read_data = 0;
  endtask

  task automatic applyStimulus(input int req_pct, input int ready_pct, input int resp_pct);
    inst_if.request      = ($urandom_range(99) < req_pct);
    inst_if.write        = $urandom_range(1);
    inst_if.size         = 2'($urandom_range(3));
    inst_if.address      = $urandom;
    inst_if.write_data   = $urandom;
    inst_if.write_strobe = 4'($urandom_range(15));
    data_if.request      = ($urandom_range(99) < req_pct);
    data_if.write        = $urandom_range(1);
    data_if.size         = 2'($urandom_range(3));
    data_if.address      = $urandom;
    data_if.write_data   = $urandom;
    data_if.write_strobe = 4'($urandom_range(15));
    ram_if.address_ready = ($urandom_range(99) < ready_pct);
    ram_if.data_ready    = ($urandom_range(99) < resp_pct);
    ram_if.read_data     = $urandom;
  endtask

  // Compare one cycle against the model, then advance the model at the edge.
  task automatic stepCycle();
    int  g;
    bit  accept, pop, bad_resp, ireq, ready;
    logic [31:0] exp_addr, exp_wdata;
    logic [6:0]  exp_ctl;
    @(negedge clock);
    #1;
    g        = modelGrant();
    ireq     = inst_if.request;
    ready    = ram_if.address_ready;
    accept   = (g >= 0) && ready;
    pop      = ram_if.data_ready && (owner_q.size() > 0);
    bad_resp = ram_if.data_ready && (owner_q.size() == 0);
    exp_addr  = (g == 1) ? data_if.address : inst_if.address;
    exp_wdata = (g == 1) ? data_if.write_data : inst_if.write_data;
    exp_ctl   = (g == 1) ? {data_if.write, data_if.size, data_if.write_strobe}
                         : {inst_if.write, inst_if.size, inst_if.write_strobe};
    checkOutput("ram_request", ram_if.request, g >= 0);
    checkOutput("ram_address", ram_if.address, exp_addr);
    checkOutput("ram_write_data", ram_if.write_data, exp_wdata);
    checkOutput("ram_ctl", {ram_if.write, ram_if.size, ram_if.write_strobe}, exp_ctl);
    checkOutput("inst_address_ready", inst_if.address_ready, accept && g == 0);
    checkOutput("data_address_ready", data_if.address_ready, accept && g == 1);
    checkOutput("inst_data_ready", inst_if.data_ready, pop && owner_q[0] == 0);
    checkOutput("data_data_ready", data_if.data_ready, pop && owner_q[0] == 1);
    checkOutput("inst_read_data", inst_if.read_data, ram_if.read_data);
    checkOutput("data_read_data", data_if.read_data, ram_if.read_data);
    checkOutput("protocol_error", protocol_error, perr);
    @(posedge clock);
    if (reset) begin
      owner_q.delete();
      lock_valid = 0; lock_owner = 0; starve = 0; perr = 0;
    end else begin
      if (pop) void'(owner_q.pop_front());
      if (accept) owner_q.push_back(g);
      if (bad_resp) perr = 1;
      lock_valid = (g >= 0) && !ready;
      if (g >= 0) lock_owner = g;
      if (!ireq) starve = 0;
      else if (accept && g == 0) starve = 0;
      else if (accept && g == 1 && starve < STARVE) starve++;
    end
    #1;
  endtask

  task automatic pulseReset();
    reset = 1;
    clearInputs();
    stepCycle();
    reset = 0;
  endtask

  initial begin
    reset = 1;
    clearInputs();
    owner_q.delete();
    lock_valid = 0; lock_owner = 0; starve = 0; perr = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
    #1;
    checkOutput("reset_ram_request", ram_if.request, 0);
    checkOutput("reset_inst_address_ready", inst_if.address_ready, 0);
    checkOutput("reset_data_address_ready", data_if.address_ready, 0);
    checkOutput("reset_inst_data_ready", inst_if.data_ready, 0);
    checkOutput("reset_protocol_error", protocol_error, 0);

    // Single fetch read answered two cycles later.
    inst_if.request = 1; inst_if.address = 32'hbfc0_0000; ram_if.address_ready = 1;
    #1 checkOutput("t1_inst_address_ready", inst_if.address_ready, 1);
    stepCycle();
    clearInputs();
    stepCycle();
    ram_if.data_ready = 1; ram_if.read_data = 32'h3c01_0001;
    #1;
    checkOutput("t1_inst_data_ready", inst_if.data_ready, 1);
    checkOutput("t1_inst_read_data", inst_if.read_data, 32'h3c01_0001);
    checkOutput("t1_data_data_ready", data_if.data_ready, 0);
    stepCycle();

    // Both sides hammer a always-ready slave: fetch wins once every nine grants.
    pulseReset();
    inst_accepts = 0;
    for (int i = 0; i < 27; i++) begin
      clearInputs();
      inst_if.request = 1; inst_if.address = 32'h1000 + i;
      data_if.request = 1; data_if.address = 32'h2000 + i;
      ram_if.address_ready = 1;
      ram_if.data_ready = (owner_q.size() > 0);
      ram_if.read_data = $urandom;
      #1 inst_accepts += int'(inst_if.address_ready);
      stepCycle();
    end
    checkOutput("starve_fetch_grants", inst_accepts, 3);

    // Fill the FIFO, then free a slot: no push on the freeing cycle.
    pulseReset();
    for (int i = 0; i < MAX_OUT; i++) begin
      clearInputs();
      inst_if.request = 1; ram_if.address_ready = 1; inst_if.address = 32'h40 + i;
      stepCycle();
    end
    #1 checkOutput("full_blocks_request", ram_if.request, 0);
    ram_if.data_ready = 1;
    #1 checkOutput("full_pop_no_push", ram_if.request, 0);
    stepCycle();
    ram_if.data_ready = 0;
    #1 checkOutput("slot_freed_request", ram_if.request, 1);
    stepCycle();

    // Response with nothing outstanding sets a sticky error.
    pulseReset();
    clearInputs();
    ram_if.data_ready = 1;
    #1 checkOutput("empty_resp_no_data_ready", {inst_if.data_ready, data_if.data_ready}, 0);
    stepCycle();
    clearInputs();
    #1 checkOutput("empty_resp_error_set", protocol_error, 1);
    stepCycle();
    pulseReset();
    #1 checkOutput("error_cleared_by_reset", protocol_error, 0);

    // Randomized traffic under several load profiles, reset between them.
    for (int phase = 0; phase < 3; phase++) begin
      for (int i = 0; i < 200; i++) begin
        case (phase)
          0:       applyStimulus(90, 100, 30);
          1:       applyStimulus(70, 40, 40);
          default: applyStimulus(50, 70, 60);
        endcase
        stepCycle();
      end
      pulseReset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction fetch requester (if stage) and the data requester (mem stage), ahead of the AXI bridge.
- Grants one address phase per cycle.
- Records which requester owns each accepted transaction in an in-order ID FIFO, and routes each in-order data_ready back to its owner.
- Data side has priority; a starvation counter guarantees fetch progress.

Parameters:
- MAX_OUTSTANDING, 4: depth of the owner-ID FIFO (power of two, ≥2); maximum accepted-but-unanswered transactions.
- STARVE_LIMIT, 8: consecutive data grants allowed while fetch is waiting, before fetch gets a forced grant.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- inst_ram_request / inst_ram_write  in  1 / 1  fetch request, write flag
- inst_ram_size  in  2  transfer size
- inst_ram_address / inst_ram_write_data  in  32 / 32  cpu_data_t
- inst_ram_write_strobe  in  4  byte strobes
- inst_ram_read_data  out  32  read data to fetch
- inst_ram_address_ready / inst_ram_data_ready  out  1 / 1  addr accepted / data returned, fetch side
- data_ram_request, _write, _size, _address, _write_data, _write_strobe  in  same widths as inst side  data requester
- data_ram_read_data, _address_ready, _data_ready  out  32 / 1 / 1  data requester returns
- ram_request, ram_write, ram_size, ram_address, ram_write_data, ram_write_strobe  out  1/1/2/32/32/4  to memory/bridge
- ram_read_data  in  32  memory read data
- ram_address_ready / ram_data_ready  in  1 / 1  memory addr_ok / data_ok
- protocol_error  out  1  sticky: data_ready seen with empty FIFO

Behaviour:
- Reset: FIFO empty, lock clear, starve count 0, protocol_error 0.
- After reset, ram_request, both *_address_ready and both *_data_ready are 0 until requests or responses arrive.
- Grant (combinational, registered lock):
  - If lock is set and the locked owner still requests, grant the locked owner.
  - Else if starve count == STARVE_LIMIT and fetch requests, grant fetch.
  - Else if data requests, grant data.
  - Else if fetch requests, grant fetch.
- Blocking: no grant while the FIFO is full. Then ram_request = 0 and both address_ready = 0. Push is never allowed on a full FIFO, even if a pop occurs the same cycle; this keeps data_ready off the request path.
- Forwarding: ram_request = granted request. All ram_* request fields are muxed from the granted side; with no grant they equal the fetch side fields.
- granted_address_ready = ram_address_ready && ram_request. The other side's address_ready is 0.
- Lock: set when ram_request && !ram_address_ready, and records the owner. Cleared on acceptance, or when the locked owner drops its request (flush). The slave sees a stable request while it stalls.
- Accept (ram_request && ram_address_ready): push owner ID (0 = inst, 1 = data), 1-cycle effect. count increments unless a pop occurs simultaneously.
- Response (ram_data_ready with FIFO not empty):
  - Pop the head; pulse head owner's *_data_ready in the same cycle, 0-cycle latency.
  - ram_read_data is broadcast to both read_data outputs unconditionally.
  - Simultaneous push and pop leaves count unchanged. Pointers wrap modulo MAX_OUTSTANDING.
- ram_data_ready with empty FIFO: ignored, no data_ready pulse, protocol_error set until reset.
- Starve counter:
  - Increments on each data accept while inst_ram_request is high, saturating at STARVE_LIMIT.
  - Clears on any inst accept, or when inst_ram_request is low.
- Reset mid-transaction: all state cleared. Late responses after reset raise protocol_error. The bridge is reset together with the arbiter.
- Writes travel the same path. A write's data_ready pops the FIFO exactly like a read's.

Decomposition:
- Add arbiter_params package holding:
  - owner_t enum (OWNER_INST, OWNER_DATA)
  - sram_request_t struct (request, write, size, address, write_data, write_strobe)
  - sram_response_t struct (read_data, address_ready, data_ready)
  - default MAX_OUTSTANDING and STARVE_LIMIT
- Reuse cpu_core_params::cpu_data_t.
- One natural sub-module: owner_fifo, a parameterised sync FIFO of owner_t with push/pop/full/empty/head and count.

Test Plan:
- Single fetch read, slave addr_ok same cycle, data_ok 2 cycles later with rdata 0x3c010001 -> inst_address_ready pulses on cycle 0; inst_data_ready and read_data 0x3c010001 on cycle 2; data side stays silent.
- Both request every cycle, slave always ready, STARVE_LIMIT=8 -> 8 data grants, then 1 fetch grant, repeating; FIFO order matches; every data_ready is routed to the correct owner.
- Slave holds addr_ok low 3 cycles on a fetch request while data request rises -> ram_address stays at the fetch address all 3 cycles; data is granted next after acceptance.
- Fetch request dropped while locked and stalled, data requesting -> lock releases, data granted the next cycle, no FIFO push for fetch.
- 4 accepts with no data_ok (MAX_OUTSTANDING=4) -> ram_request 0 while full; one data_ok frees a slot, and the next request is accepted the cycle after.
- ram_data_ready pulse with FIFO empty -> no *_data_ready, protocol_error = 1 until reset; reset clears it and the FIFO.
